des_key_schedule: RTL
=====================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 Parameters: none; all widths and shift tables SHALL be fixed per FIPS 46-3.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a 16-round schedule; SHALL be accepted only in IDLE.
REQ-005 decrypt  input  1  0 = emit K1..K16, 1 = emit K16..K1; SHALL be sampled only at start acceptance.
REQ-006 pc1_key  input  56  PC-1 output; bit 55 = FIPS bit 1; C0 = pc1_key[55:28], D0 = pc1_key[27:0]; SHALL be sampled only at start acceptance.
REQ-007 subkey  output  48  current round key; bit 47 = FIPS bit 1.
REQ-008 subkey_valid  output  1  subkey and round_idx are valid.
REQ-009 subkey_ready  input  1  consumer accepts subkey when high together with subkey_valid.
REQ-010 round_idx  output  4  index of the emitted subkey in emission order, 0..15.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse after the 16th subkey is accepted.

Function
REQ-013 States: IDLE, RUN, DONE.
REQ-014 The block SHALL hold a 28-bit C register, a 28-bit D register and a 4-bit round counter.
REQ-015 IDLE with start=1: encrypt loads C,D = C0,D0 rotated left by 1; decrypt loads C,D = C0,D0 unrotated; round counter cleared; next state RUN.
REQ-016 Latency: start accepted at edge N -> subkey_valid=1 with round_idx=0 after edge N.
REQ-017 subkey SHALL equal PC-2 (FIPS 46-3 table) applied to {C,D}, as combinational logic from the registers; no extra pipeline stage.
REQ-018 In RUN, subkey_valid SHALL be 1; a transfer occurs on a rising edge where subkey_valid and subkey_ready are both 1.
REQ-019 subkey_ready=0 in RUN: C, D, round counter, subkey and round_idx SHALL hold unchanged; no timeout.
REQ-020 On a transfer with round_idx<15, round_idx SHALL increment.
REQ-021 Encrypt advance: rotate C and D left by the FIPS shift for the next round (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 indexed by round).
REQ-022 Decrypt advance: rotate C and D right by the encrypt shift of the round just emitted (round j emits K(16-j); shift = encrypt shift of round 16-j).
REQ-023 A transfer with round_idx=15 SHALL move to DONE; subkey_valid=0 from the next cycle.
REQ-024 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-025 start in RUN or DONE SHALL be ignored, with no queuing; start in the IDLE cycle following DONE SHALL be accepted.
REQ-026 subkey_ready SHALL be ignored outside RUN.
REQ-027 Changes to pc1_key and decrypt after acceptance SHALL not affect the schedule in progress.
REQ-028 All rotations SHALL be modulo 28 within each half; C and D bits SHALL never mix.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, clear C, D and the round counter, and drive subkey_valid=0, done=0, busy=0 and round_idx=0, independent of clk.
REQ-030 subkey SHALL read PC2(0)=0 during reset.
REQ-031 rst asserted mid-schedule SHALL abort the schedule with no done pulse.
REQ-032 After rst deasserts, the first start SHALL begin a fresh schedule.

Verification
REQ-033 Encrypt, pc1_key=F0CCAAF556678F, subkey_ready=1 constantly -> round 0 subkey=1B02EFFC7072, round 15 subkey=CB3D8B0E17F5, 16 valid cycles, then done pulse one cycle later.
REQ-034 Decrypt, same key -> round 0 subkey=CB3D8B0E17F5, round 15 subkey=1B02EFFC7072, full sequence equal to encrypt order reversed.
REQ-035 Encrypt with subkey_ready toggled pseudo-randomly -> same 16 subkeys in order; subkey and round_idx stable on every stalled cycle.
REQ-036 start pulsed in RUN at round 5 and in the DONE cycle -> ignored; sequence unchanged and a single done pulse.
REQ-037 rst asserted at round 7 between clock edges -> subkey_valid and busy fall immediately, no done pulse; a new start then yields round 0 subkey=1B02EFFC7072.
REQ-038 Encrypt with pc1_key changed every cycle after start -> output identical to REQ-033.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// Handshake bundle between a DES key-schedule generator and its subkey consumer.
interface des_key_schedule_if;
    logic        start;
    logic        decrypt;
    logic [55:0] pc1_key;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    modport master (
        output start, decrypt, pc1_key, subkey_ready,
        input  subkey, subkey_valid, round_idx, busy, done
    );

    modport slave (
        input  start, decrypt, pc1_key, subkey_ready,
        output subkey, subkey_valid, round_idx, busy, done
    );
endinterface

// File: rtl/des_key_schedule.sv
// DES round-key generator: walks the C/D halves through 16 rotations and emits PC-2
// of each state over a valid/ready handshake, in forward or reverse order.
module des_key_schedule (
    input logic               clk,
    input logic               rst,
    des_key_schedule_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Bit r set where round r (0-based) rotates by two instead of one.
    localparam logic [15:0] ShiftTwo = 16'h7EFC;

    localparam int Pc2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_e      state_q;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [3:0]  round_q;
    logic        dec_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;

    logic        two_enc;
    logic        two_dec;
    logic [55:0] cd;

    function automatic logic [27:0] rol(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Encrypt steps to the next round's shift; decrypt undoes the shift of the round just emitted.
    assign two_enc = ShiftTwo[round_q + 4'd1];
    assign two_dec = ShiftTwo[4'd15 - round_q];
    assign cd      = {c_q, d_q};

    // FIPS bit n of the 56-bit CD word lives at cd[56-n]; subkey bit 47 is FIPS bit 1.
    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign bus.subkey[47-i] = cd[56-Pc2[i]];
    end

    assign bus.subkey_valid = valid_q;
    assign bus.round_idx    = round_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        dec_q   <= bus.decrypt;
                        round_q <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                        if (bus.decrypt) begin
                            c_q <= bus.pc1_key[55:28];
                            d_q <= bus.pc1_key[27:0];
                        end else begin
                            c_q <= rol(bus.pc1_key[55:28], 1'b0);
                            d_q <= rol(bus.pc1_key[27:0], 1'b0);
                        end
                    end
                end
                StRun: begin
                    if (bus.subkey_ready) begin
                        if (round_q == 4'd15) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            round_q <= round_q + 4'd1;
                            if (dec_q) begin
                                c_q <= ror(c_q, two_dec);
                                d_q <= ror(d_q, two_dec);
                            end else begin
                                c_q <= rol(c_q, two_enc);
                                d_q <= rol(d_q, two_enc);
                            end
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule
